// File: rtl/usb_pkg.sv
// usb_pkg: USB constants and types shared by the receive and transmit packet controllers.
package usb_pkg;

    // PID bytes as they appear on the wire. The high nibble is the complement of the low nibble.
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    // The byte that closes the SYNC field, given in first-received-bit-in-bit-0 order.
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Default maximum number of payload bytes in a DATA packet.
    localparam int MAX_DATA_DEFAULT = 64;

    // Packet type reported to the protocol controller.
    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_OUT   = 3'd1,
        PKT_IN    = 3'd2,
        PKT_DATA0 = 3'd3,
        PKT_DATA1 = 3'd4,
        PKT_ACK   = 3'd5,
        PKT_NAK   = 3'd6
    } rx_packet_e;

    // Maps a received PID byte to its packet type. Any byte that is not one of the
    // six supported PIDs returns PKT_NONE. This includes every byte whose check nibble
    // is not the complement of its type nibble.
    function automatic rx_packet_e decode_pid(input logic [7:0] pid);
        rx_packet_e v_type;
        case (pid)
            PID_OUT:   v_type = PKT_OUT;
            PID_IN:    v_type = PKT_IN;
            PID_DATA0: v_type = PKT_DATA0;
            PID_DATA1: v_type = PKT_DATA1;
            PID_ACK:   v_type = PKT_ACK;
            PID_NAK:   v_type = PKT_NAK;
            // NOTE: the default arm assigns on every path, so combinational use cannot infer a latch.
            default:   v_type = PKT_NONE;
        endcase
        return v_type;
    endfunction

endpackage

// File: rtl/usb_rx_hold2.sv
// usb_rx_hold2: two-byte holding pipeline. It delays DATA payload bytes by two
// positions, so the trailing CRC16 is still held at end-of-packet and never reaches the buffer.
module usb_rx_hold2 (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_push,
    input  logic       i_flush,
    input  logic [7:0] i_byte,
    output logic       o_full,
    output logic [1:0] o_count,
    output logic [7:0] o_oldest
);

    logic [7:0] r_hold0;
    logic [7:0] r_hold1;
    logic [1:0] r_count;

    // Shift a byte in on push, and empty the pipeline on flush at the start of a payload.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: the held bytes are reset together with the count, so no stale payload byte can surface as oldest after reset.
            r_hold0 <= '0;
            r_hold1 <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
            r_count <= '0;
        end else if (i_push) begin
            // NOTE: non-blocking, so hold1 receives the previous hold0 and not the byte arriving this cycle.
            r_hold1 <= r_hold0;
            r_hold0 <= i_byte;
            if (r_count != 2'd2) begin
                r_count <= r_count + 2'd1;
            end
        end
    end

    assign o_full   = (r_count == 2'd2);
    assign o_count  = r_count;
    assign o_oldest = r_hold1;

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive-side packet controller. It frames unstuffed bytes into USB
// packets, checks SYNC and PID, captures token bytes, writes DATA payload bytes to
// the endpoint buffer with the CRC16 stripped, and reports the outcome of each packet.
module usb_rx_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_DATA = MAX_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_start_edge,
    input  logic        i_byte_done,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_eop,
    input  logic        i_crc16_ok,
    output logic        o_crc_clear,
    output logic        o_flush_buffer,
    output logic        o_store_rx_data,
    output logic [7:0]  o_rx_data,
    output logic [2:0]  o_rx_packet,
    output logic [15:0] o_rx_token,
    output logic [6:0]  o_rx_data_size,
    output logic        o_rx_done,
    output logic        o_rx_error,
    output logic        o_rx_active
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOKEN,
        ST_DATA,
        ST_HSHK,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e     r_state;
    rx_packet_e r_pkt_type;
    logic [1:0] r_tok_cnt;

    logic       w_byte;
    logic       w_eop;
    logic       w_clash;
    rx_packet_e w_pid;
    logic       w_is_data_pid;
    logic       w_push;
    logic       w_flush;
    logic       w_hold_full;
    logic [1:0] w_hold_count;
    logic [7:0] w_hold_oldest;

    // A byte that completes on the eop cycle is a truncated byte. Split the strobes so
    // each state handles only a clean byte or a clean eop.
    assign w_byte  = i_byte_done & ~i_eop;
    assign w_eop   = i_eop & ~i_byte_done;
    assign w_clash = i_byte_done & i_eop;

    assign w_pid         = decode_pid(i_rx_byte);
    assign w_is_data_pid = (w_pid == PKT_DATA0) || (w_pid == PKT_DATA1);
    assign w_flush       = (r_state == ST_PID) && w_byte && w_is_data_pid;
    assign w_push        = (r_state == ST_DATA) && w_byte;

    usb_rx_hold2 u_hold (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_push   (w_push),
        .i_flush  (w_flush),
        .i_byte   (i_rx_byte),
        .o_full   (w_hold_full),
        .o_count  (w_hold_count),
        .o_oldest (w_hold_oldest)
    );

    // Packet framing FSM with registered outputs. Every error detected on an eop cycle
    // has already seen its terminating eop, so it returns straight to IDLE with rx_error set.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= ST_IDLE;
            r_pkt_type      <= PKT_NONE;
            r_tok_cnt       <= '0;
            o_crc_clear     <= 1'b0;
            o_flush_buffer  <= 1'b0;
            o_store_rx_data <= 1'b0;
            o_rx_data       <= '0;
            o_rx_packet     <= PKT_NONE;
            o_rx_token      <= '0;
            o_rx_data_size  <= '0;
            o_rx_done       <= 1'b0;
            o_rx_error      <= 1'b0;
            o_rx_active     <= 1'b0;
        end else begin
            o_crc_clear     <= 1'b0;
            o_flush_buffer  <= 1'b0;
            o_store_rx_data <= 1'b0;
            o_rx_done       <= 1'b0;

            if ((r_state != ST_IDLE) && (r_state != ST_DONE) && w_clash) begin
                r_state     <= ST_IDLE;
                o_rx_error  <= 1'b1;
                o_rx_active <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start_edge) begin
                            r_state     <= ST_SYNC;
                            o_crc_clear <= 1'b1;
                            o_rx_active <= 1'b1;
                            o_rx_error  <= 1'b0;
                            o_rx_packet <= PKT_NONE;
                            o_rx_token  <= '0;
                        end else begin
                            o_rx_active <= 1'b0;
                        end
                    end

                    ST_SYNC: begin
                        if (w_byte) begin
                            if (i_rx_byte == SYNC_BYTE) begin
                                r_state <= ST_PID;
                            end else begin
                                r_state    <= ST_ERR;
                                o_rx_error <= 1'b1;
                            end
                        end else if (w_eop) begin
                            r_state     <= ST_IDLE;
                            o_rx_error  <= 1'b1;
                            o_rx_active <= 1'b0;
                        end
                    end

                    ST_PID: begin
                        if (w_byte) begin
                            r_pkt_type <= w_pid;
                            case (w_pid)
                                PKT_OUT, PKT_IN: begin
                                    r_state   <= ST_TOKEN;
                                    r_tok_cnt <= '0;
                                end
                                PKT_DATA0, PKT_DATA1: begin
                                    r_state        <= ST_DATA;
                                    o_flush_buffer <= 1'b1;
                                    o_rx_data_size <= '0;
                                end
                                PKT_ACK, PKT_NAK: begin
                                    r_state <= ST_HSHK;
                                end
                                default: begin
                                    r_state    <= ST_ERR;
                                    o_rx_error <= 1'b1;
                                end
                            endcase
                        end else if (w_eop) begin
                            r_state     <= ST_IDLE;
                            o_rx_error  <= 1'b1;
                            o_rx_active <= 1'b0;
                        end
                    end

                    ST_TOKEN: begin
                        if (w_byte) begin
                            if (r_tok_cnt == 2'd0) begin
                                o_rx_token[7:0] <= i_rx_byte;
                                r_tok_cnt       <= 2'd1;
                            end else if (r_tok_cnt == 2'd1) begin
                                o_rx_token[15:8] <= i_rx_byte;
                                r_tok_cnt        <= 2'd2;
                            end else begin
                                r_state    <= ST_ERR;
                                o_rx_error <= 1'b1;
                            end
                        end else if (w_eop) begin
                            if (r_tok_cnt == 2'd2) begin
                                r_state     <= ST_DONE;
                                o_rx_packet <= r_pkt_type;
                            end else begin
                                r_state     <= ST_IDLE;
                                o_rx_error  <= 1'b1;
                                o_rx_active <= 1'b0;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (w_byte && w_hold_full) begin
                            if (o_rx_data_size == 7'(MAX_DATA)) begin
                                r_state    <= ST_ERR;
                                o_rx_error <= 1'b1;
                            end else begin
                                o_store_rx_data <= 1'b1;
                                o_rx_data       <= w_hold_oldest;
                                o_rx_data_size  <= o_rx_data_size + 7'd1;
                            end
                        end else if (w_eop) begin
                            if ((w_hold_count == 2'd2) && i_crc16_ok) begin
                                r_state     <= ST_DONE;
                                o_rx_packet <= r_pkt_type;
                            end else begin
                                r_state     <= ST_IDLE;
                                o_rx_error  <= 1'b1;
                                o_rx_active <= 1'b0;
                            end
                        end
                    end

                    ST_HSHK: begin
                        if (w_byte) begin
                            r_state    <= ST_ERR;
                            o_rx_error <= 1'b1;
                        end else if (w_eop) begin
                            r_state     <= ST_DONE;
                            o_rx_packet <= r_pkt_type;
                        end
                    end

                    ST_DONE: begin
                        r_state   <= ST_IDLE;
                        o_rx_done <= 1'b1;
                    end

                    ST_ERR: begin
                        if (w_eop) begin
                            r_state     <= ST_IDLE;
                            o_rx_active <= 1'b0;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Receive-side packet controller for the USB full-speed endpoint. It sits above the line-level receive chain (edge detector, NRZI decoder, bit unstuffer, 8-bit serial-in shift register) and below the endpoint data buffer and protocol controller. It frames incoming bytes into packets, validates SYNC and PID, strips the CRC16 from data payloads, writes payload bytes into the buffer, and reports packet type, size and errors. It is the counterpart of the transmit FSM and uses the same PID byte encodings.

## Interface
- MAX_DATA, 64: maximum payload bytes per DATA packet.
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- start_edge  input  1  one-cycle pulse: first bus transition seen while the bus is idle.
- byte_done  input  1  one-cycle pulse: rx_byte holds a complete, unstuffed byte.
- rx_byte  input  8  assembled byte, first-received bit in bit 0.
- eop  input  1  one-cycle pulse: end-of-packet (SE0 followed by J) detected.
- crc16_ok  input  1  external CRC16 checker residual correct; sampled only on the eop cycle.
- crc_clear  output  1  one-cycle pulse that restarts the external CRC checker.
- flush_buffer  output  1  one-cycle pulse that empties the data buffer before a new payload.
- store_rx_data  output  1  one-cycle write strobe to the data buffer.
- rx_data  output  8  payload byte, valid while store_rx_data is high.
- rx_packet  output  3  0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK.
- rx_token  output  16  the two token bytes following an OUT or IN PID, with the first byte in [7:0].
- rx_data_size  output  7  number of payload bytes stored.
- rx_done  output  1  one-cycle pulse: packet accepted; rx_packet, rx_token and rx_data_size are valid.
- rx_error  output  1  held high from error detection until the next start_edge.
- rx_active  output  1  high from start_edge until return to IDLE.

## Operation
- States: IDLE, SYNC, PID, TOKEN, DATA, HSHK, DONE, ERR.
- IDLE: on start_edge, go to SYNC, pulse crc_clear, set rx_active and clear rx_error.
- SYNC: on byte_done, an rx_byte value of 8'h80 goes to PID; any other value goes to ERR.
- PID: on byte_done, decode rx_byte.
  - 8'hE1 is OUT and 8'h69 is IN; both go to TOKEN.
  - 8'hC3 is DATA0 and 8'h4B is DATA1; both go to DATA and pulse flush_buffer.
  - 8'hD2 is ACK and 8'h5A is NAK; both go to HSHK.
  - Any other byte, including one whose high nibble is not the complement of its low nibble, goes to ERR.
  - The PID byte is never fed to the CRC checker and never stored.
- TOKEN: accept exactly 2 bytes into rx_token.
  - eop after 2 bytes goes to DONE.
  - eop before 2 bytes, or a third byte, goes to ERR.
- DATA: incoming bytes pass through a 2-byte holding pipeline (hold0, hold1).
  - On each byte_done when the pipeline is full, write hold1 (store_rx_data, rx_data = hold1), shift, and increment the count.
  - The two bytes still held at eop are the CRC16 and are discarded.
  - eop with fewer than 2 bytes held, or with crc16_ok low, goes to ERR.
  - A store that would exceed MAX_DATA goes to ERR.
- HSHK: eop goes to DONE; any byte_done goes to ERR.
- DONE: pulse rx_done for one cycle, then go to IDLE.
- ERR: set rx_error and wait for eop, then go to IDLE. rx_packet is 0 after an error.
- byte_done and eop in the same cycle, in any non-IDLE state: go to ERR (partial byte).
- start_edge outside IDLE is ignored.
- byte_done or eop in IDLE is ignored.
- Width rules:
  - The byte counter is 7 bits.
  - rx_data_size equals the count of store_rx_data pulses in the current packet.
  - rx_data_size is zeroed by flush_buffer.

## Timing
- All outputs are registered. On reset every output is 0, the state is IDLE, and the holding pipeline and counter are cleared.
- crc_clear: asserted in the cycle after start_edge.
- flush_buffer: asserted in the cycle after the DATA PID byte_done.
- store_rx_data: asserted in the cycle after the byte_done that triggers it.
- rx_done: asserted 2 cycles after eop (eop→DONE, DONE→IDLE with the pulse).
- rx_active: deasserts in the cycle after rx_done, or after the ERR-terminating eop.
- rx_packet and rx_token are held until the next start_edge.
- Reset mid-packet aborts immediately with no store, no rx_done and no error.

## Structure
- Shared package usb_pkg:
  - PID byte constants (also used by the TX side).
  - the rx_packet enum.
  - the SYNC byte constant 8'h80.
  - the MAX_DATA default.
- The state typedef is local to the module.
- Sub-module usb_rx_hold2: the 2-byte CRC-stripping holding pipeline. It has push, flush, full and count ports, and outputs the oldest byte.

## Test plan
- SYNC 80, PID C3, payload 11 22 33, CRC bytes, eop with crc16_ok=1 → three stores of 11, 22, 33; rx_data_size=3; rx_packet=3; one rx_done.
- SYNC 80, PID E1, bytes 5A 0F, eop → rx_packet=1, rx_token=16'h0F5A, rx_done, no stores.
- SYNC 80, PID D2, eop → rx_packet=5, rx_done 2 cycles after eop.
- Bad PID 8'hC4 → rx_error=1, no rx_done, IDLE after eop; a following valid ACK packet clears rx_error and completes.
- DATA packet with crc16_ok=0 at eop, and a separate DATA packet of MAX_DATA+1 payload bytes → rx_error=1, no rx_done.
- n_rst asserted mid-DATA after 2 stores → all outputs 0 and the state is IDLE; a subsequent NAK packet is received normally with rx_packet=6.
